// File: rtl/multicycle_add_ctrl.sv
// -----------------------------------------------------------------------------
// multicycle_add_ctrl
//
// Sequences a WIDTH-bit addition through a narrow external combinational adder
// slice, one SLICE-wide chunk per clock, least-significant chunk first. The
// carry out of each chunk is registered and fed back as the carry into the next
// chunk. The result is held with a valid/ready handshake until the consumer
// takes it.
//
// Parameters
//   WIDTH      full operand width
//   SLICE      width of the external adder slice (WIDTH must be a multiple)
//
// Ports
//   clk        single clock, all state updates on its rising edge
//   rst        asynchronous active-high reset
//   in_valid   operand request valid
//   in_ready   block can accept operands (IDLE only)
//   a, b, cin  operands and carry-in, latched on the accepting edge
//   out_valid  result valid (DONE only)
//   out_ready  consumer accepts the result
//   sum, cout  result; meaningful only while out_valid=1
//   busy       high whenever a transaction is in flight or being held
//   slc_a/b    operand chunk presented to the external slice
//   slc_cin    carry presented to the external slice
//   slc_sum    slice sum returned in the same cycle
//   slc_cout   slice carry-out returned in the same cycle
// -----------------------------------------------------------------------------
module multicycle_add_ctrl #(
  parameter int WIDTH = 64,
  parameter int SLICE = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             busy,
  output logic [SLICE-1:0] slc_a,
  output logic [SLICE-1:0] slc_b,
  output logic             slc_cin,
  input  logic [SLICE-1:0] slc_sum,
  input  logic             slc_cout
);

  localparam int NSLICE = WIDTH / SLICE;
  // $clog2(1) is 0, so a single-slice build still gets a 1-bit index.
  localparam int IDX_W  = (NSLICE > 1) ? $clog2(NSLICE) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NSLICE - 1);

  if ((WIDTH % SLICE) != 0 || SLICE <= 0) begin : g_bad_params
    $error("multicycle_add_ctrl: WIDTH must be a positive multiple of SLICE");
  end

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state;
  state_t           state_nxt;

  logic [IDX_W-1:0] idx;
  logic             carry;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic             cin_q;

  logic             accept;
  logic             step;
  logic             last_step;

  // ---------------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------------
  // NOTE: sequential state is always written with non-blocking assignments so
  // every flop samples the pre-edge values regardless of block ordering.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state and output decode
  // ---------------------------------------------------------------------------
  // NOTE: every signal written here gets a default first; a path that left one
  // unassigned would infer a latch.
  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b1;
    accept    = 1'b0;
    step      = 1'b0;
    last_step = 1'b0;
    slc_a     = '0;
    slc_b     = '0;
    slc_cin   = 1'b0;

    unique case (state)
      IDLE: begin
        in_ready = 1'b1;
        busy     = 1'b0;
        if (in_valid) begin
          accept    = 1'b1;
          state_nxt = RUN;
        end
      end

      RUN: begin
        step      = 1'b1;
        last_step = (idx == LAST_IDX);
        slc_a     = a_q[int'(idx)*SLICE +: SLICE];
        slc_b     = b_q[int'(idx)*SLICE +: SLICE];
        // The first chunk takes the caller's carry-in; later chunks chain the
        // carry registered from the previous chunk.
        slc_cin   = (idx == '0) ? cin_q : carry;
        if (last_step) begin
          state_nxt = DONE;
        end
      end

      DONE: begin
        out_valid = 1'b1;
        // Handoff returns to IDLE only; a new request is taken on a later edge.
        if (out_ready) begin
          state_nxt = IDLE;
        end
      end

      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Datapath: operand latch, slice index, carry chain and result assembly
  // ---------------------------------------------------------------------------
  // NOTE: the operand and result registers are reset too, so that an aborted
  // transaction leaves nothing stale visible on sum/cout after reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idx   <= '0;
      carry <= 1'b0;
      a_q   <= '0;
      b_q   <= '0;
      cin_q <= 1'b0;
      sum   <= '0;
      cout  <= 1'b0;
    end else if (accept) begin
      a_q   <= a;
      b_q   <= b;
      cin_q <= cin;
      idx   <= '0;
    end else if (step) begin
      sum[int'(idx)*SLICE +: SLICE] <= slc_sum;
      carry                          <= slc_cout;
      if (last_step) begin
        // Park the index at 0 rather than letting it run past the last slice.
        idx  <= '0;
        cout <= slc_cout;
      end else begin
        idx <= idx + 1'b1;
      end
    end
  end

endmodule
